// File: rtl/harb_audio_pkg.sv
// Shared types and constants for the audio output path.
package harb_audio_pkg;

  typedef logic signed [15:0] sample_t;

  localparam int FRAME_DIV_48K = 768;
  localparam int BCLK_DIV_48K  = 12;

  typedef enum logic [1:0] {IDLE, SUM, SCALE, SAT} mix_state_t;

  // Frame-start snapshot of the mixer controls
  typedef struct packed {
    logic [15:0] vol;
    logic        mute;
  } mix_ctl_t;

  // Clamp a scaled sum to 16 bits; bit 16 flags that clamping occurred
  function automatic logic [16:0] sat16(input logic signed [36:0] v);
    if (v > 37'sd32767)       return {1'b1, 16'h7FFF};
    else if (v < -37'sd32768) return {1'b1, 16'h8000};
    else                      return {1'b0, v[15:0]};
  endfunction

endpackage

// File: rtl/i2s_tx.sv
// Frame/bit timing and I2S serialiser; one 16-bit sample sent on both slots.
module i2s_tx #(
  parameter int FRAME_DIV = 768,
  parameter int BCLK_DIV  = 12
) (
  input  logic        clk37,
  input  logic        rst,
  input  logic [15:0] pending,
  output logic        frame_tick,
  output logic        frame_strobe,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata
);

  localparam int BITS = FRAME_DIV / BCLK_DIV;
  localparam int PW   = $clog2(BCLK_DIV);
  localparam int BW   = $clog2(BITS);

  logic [PW-1:0] p;
  logic [BW-1:0] b;
  logic [15:0]   shift;
  logic [4:0]    s;
  logic [3:0]    bit_sel;

  // Slot position within the current channel, and which sample bit it carries
  assign s          = b[4:0];
  assign bit_sel    = 4'(5'd16 - s);
  assign frame_tick = (p == '0) && (b == '0);

  // Frame counter kept as bit index b and phase p (f = b*BCLK_DIV + p)
  always_ff @(posedge clk37) begin
    if (rst) begin
      p <= '0;
      b <= '0;
    end else if (p == PW'(BCLK_DIV - 1)) begin
      p <= '0;
      b <= (b == BW'(BITS - 1)) ? '0 : b + 1'b1;
    end else begin
      p <= p + 1'b1;
    end
  end

  // Registered pins; lrclk/sdata only move at the start of a bit (bclk falling)
  always_ff @(posedge clk37) begin
    if (rst) begin
      frame_strobe <= 1'b0;
      i2s_bclk     <= 1'b0;
      i2s_lrclk    <= 1'b0;
      i2s_sdata    <= 1'b0;
      shift        <= '0;
    end else begin
      frame_strobe <= frame_tick;
      i2s_bclk     <= (p >= PW'(BCLK_DIV / 2));
      if (p == '0) begin
        i2s_lrclk <= b[BW-1];
        i2s_sdata <= ((s != 5'd0) && (s <= 5'd16)) ? shift[bit_sel] : 1'b0;
      end
      if (frame_tick) shift <= pending;
    end
  end

endmodule

// File: rtl/voice_hold.sv
// Per-voice holding register: latches the voice sample on its ready pulse.
module voice_hold (
  input  logic        clk37,
  input  logic        rst,
  input  logic        ready,
  input  logic [15:0] din,
  output logic [15:0] q
);

  // Keep the last delivered sample until the voice produces a new one
  always_ff @(posedge clk37) begin
    if (rst)        q <= '0;
    else if (ready) q <= din;
  end

endmodule

// File: rtl/voice_mixer_i2s.sv
// Voice mixer: capture, per-frame sum, master volume with saturation, I2S out.
module voice_mixer_i2s
  import harb_audio_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int FRAME_DIV  = FRAME_DIV_48K,
  parameter int BCLK_DIV   = BCLK_DIV_48K,
  parameter int MIX_SHIFT  = 0
) (
  input  logic                    clk37,
  input  logic                    rst,
  input  logic [16*NUM_VOICES-1:0] voice_sample,
  input  logic [NUM_VOICES-1:0]   voice_ready,
  input  logic [15:0]             master_vol,
  input  logic                    mute,
  input  logic                    clip_clr,
  output logic                    i2s_bclk,
  output logic                    i2s_lrclk,
  output logic                    i2s_sdata,
  output logic                    frame_strobe,
  output logic                    clip
);

  localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic [NUM_VOICES-1:0][15:0] hold;
  logic [NUM_VOICES-1:0][15:0] snap;
  mix_ctl_t                    ctl;
  mix_state_t                  state;
  logic [IW-1:0]               idx;
  logic signed [19:0]          acc;
  logic signed [19:0]          acc_sh;
  logic signed [36:0]          prod_q;
  logic [16:0]                 sat_r;
  sample_t                     pending;
  logic                        tick;

  for (genvar k = 0; k < NUM_VOICES; k++) begin : g_voice
    voice_hold u_hold (
      .clk37 (clk37),
      .rst   (rst),
      .ready (voice_ready[k]),
      .din   (voice_sample[16*k +: 16]),
      .q     (hold[k])
    );
  end

  i2s_tx #(
    .FRAME_DIV (FRAME_DIV),
    .BCLK_DIV  (BCLK_DIV)
  ) u_tx (
    .clk37        (clk37),
    .rst          (rst),
    .pending      (pending),
    .frame_tick   (tick),
    .frame_strobe (frame_strobe),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_sdata    (i2s_sdata)
  );

  assign acc_sh = acc >>> MIX_SHIFT;
  assign sat_r  = sat16(prod_q >>> 16);

  // Mix FSM: snapshot at frame start, sum one voice per cycle, scale, clamp
  always_ff @(posedge clk37) begin
    if (rst) begin
      state   <= IDLE;
      snap    <= '0;
      ctl     <= '0;
      idx     <= '0;
      acc     <= '0;
      prod_q  <= '0;
      pending <= '0;
      clip    <= 1'b0;
    end else begin
      // A clip detected in SAT below overrides this clear
      if (clip_clr) clip <= 1'b0;
      if (tick) begin
        snap  <= hold;
        ctl   <= '{vol: master_vol, mute: mute};
        idx   <= '0;
        acc   <= '0;
        state <= SUM;
      end else begin
        case (state)
          SUM: begin
            acc <= acc + {{4{snap[idx][15]}}, snap[idx]};
            if (idx == IW'(NUM_VOICES - 1)) state <= SCALE;
            else                            idx   <= idx + 1'b1;
          end
          SCALE: begin
            prod_q <= 37'(acc_sh) * 37'($signed({1'b0, ctl.vol}));
            state  <= SAT;
          end
          SAT: begin
            pending <= ctl.mute ? '0 : sat_r[15:0];
            if (!ctl.mute && sat_r[16]) clip <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
